// File: rtl/demux1_4_burst.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and burst locking.
// Optional per-channel accept counters are built when DEMUX_CNT_EN is defined.
module demux1_4_burst #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] x,
    input  logic [1:0]   s,
    input  logic         x_valid,
    input  logic         x_last,
    output logic         x_ready,
    output logic [W-1:0] f0,
    output logic [W-1:0] f1,
    output logic [W-1:0] f2,
    output logic [W-1:0] f3,
    output logic [3:0]   f_valid,
    input  logic [3:0]   f_ready,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
    output logic [7:0]   cnt2,
    output logic [7:0]   cnt3
);

    // Handshake: a word moves on any rising edge where x_valid and x_ready are
    // both high; a channel word moves when f_valid[i] and f_ready[i] are high.

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       r_state;
    logic [1:0]   r_ch;
    logic [W-1:0] r_f [4];
    logic [3:0]   r_fv;

    logic [1:0]   w_t;
    logic         w_accept;

    // During a burst the latched channel wins over the live select.
    assign w_t      = (r_state == IDLE) ? s : r_ch;
    assign x_ready  = rst_n & (~r_fv[w_t] | f_ready[w_t]);
    assign w_accept = x_valid & x_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ch    <= 2'd0;
        end else if (w_accept) begin
            if (r_state == IDLE && !x_last) begin
                r_state <= LOCK;
                r_ch    <= s;
            end else if (r_state == LOCK && x_last) begin
                r_state <= IDLE;
            end
        end
    end

    // A load on the same edge as a drain keeps valid high: no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fv <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_f[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept && (w_t == 2'(i))) begin
                    r_f[i]  <= x;
                    r_fv[i] <= 1'b1;
                end else if (r_fv[i] && f_ready[i]) begin
                    r_fv[i] <= 1'b0;
                end
            end
        end
    end

    assign f0      = r_f[0];
    assign f1      = r_f[1];
    assign f2      = r_f[2];
    assign f3      = r_f[3];
    assign f_valid = r_fv;

`ifdef DEMUX_CNT_EN
    logic [7:0] r_cnt [4];

    // Counters wrap naturally from 255 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept && (w_t == 2'(i))) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`else
    assign cnt0 = 8'h00;
    assign cnt1 = 8'h00;
    assign cnt2 = 8'h00;
    assign cnt3 = 8'h00;
`endif

endmodule
